// File: rtl/pwm_envelope_gen_pkg.sv
// rtl/pwm_envelope_gen_pkg.sv - shared encodings and sizing for the PWM envelope generator
package pwm_envelope_gen_pkg;

  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FADE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'b00,
    MODE_TRIANGLE = 2'b01,
    MODE_SAW      = 2'b10,
    MODE_FULL     = 2'b11
  } mode_t;

  // Duty word needs one extra bit so that "always on" (2^CNT_W) is representable.
  function automatic int duty_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/pwm_envelope_gen_switch_debounce.sv
// rtl/pwm_envelope_gen_switch_debounce.sv - synchronizer plus stability-counter debouncer for a raw switch
module switch_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_clean;
  logic [DEBOUNCE_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has disagreed with the clean value for the full counter span.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (r_sync2 == r_clean) begin
      r_cnt <= '0;
    end else if (&r_cnt) begin
      r_clean <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign clean = r_clean;

endmodule

// File: rtl/pwm_envelope_gen.sv
// rtl/pwm_envelope_gen.sv - carrier counter, waveform shaping and IDLE/RUN/FADE duty sequencing
module pwm_envelope_gen
  import pwm_envelope_gen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int DEBOUNCE_W = 16,
  parameter int FADE_STEP  = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable_sw,
  input  logic [1:0]       mode_sw,
  output logic [CNT_W-1:0] carrier_cnt,
  output logic [CNT_W:0]   duty_cycle,
  output logic             duty_update,
  output logic             enable_clean,
  output logic [1:0]       state
);

  localparam int                DUTY_W = duty_w(CNT_W);
  localparam logic [DUTY_W-1:0] FULL   = DUTY_W'(1 << CNT_W);
  localparam logic [DUTY_W-1:0] STEP   = DUTY_W'(FADE_STEP);
  localparam logic [CNT_W-1:0]  Q1     = CNT_W'(1 << (CNT_W - 2));
  localparam logic [CNT_W-1:0]  Q3     = CNT_W'(3 << (CNT_W - 2));
  localparam logic [CNT_W-1:0]  HALF   = CNT_W'(1 << (CNT_W - 1));

  logic [CNT_W-1:0]  r_carrier;
  logic [1:0]        r_mode_s1;
  logic [1:0]        r_mode_s2;
  mode_t             r_mode;
  logic [CNT_W-1:0]  r_phase;
  logic [CNT_W-1:0]  r_amp;
  logic [DUTY_W-1:0] r_duty;
  logic              r_update;
  state_t            r_state;

  logic              w_tick;
  logic              w_clean;
  state_t            w_next_state;
  logic [DUTY_W-1:0] w_duty_next;
  logic [DUTY_W-1:0] w_target;

  switch_debounce #(
    .DEBOUNCE_W(DEBOUNCE_W)
  ) u_enable_debounce (
    .sysclk(sysclk),
    .reset (reset),
    .raw   (enable_sw),
    .clean (w_clean)
  );

  assign w_tick = &r_carrier;

  // Free-running carrier shared with the downstream comparators.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_carrier <= '0;
    end else begin
      r_carrier <= r_carrier + 1'b1;
    end
  end

  // Mode select: synchronize, then latch only while idle or at a waveform cycle boundary.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
      r_mode    <= MODE_SQUARE;
    end else begin
      r_mode_s1 <= mode_sw;
      r_mode_s2 <= r_mode_s1;
      if (r_state == ST_IDLE || (w_tick && (&r_phase))) begin
        r_mode <= mode_t'(r_mode_s2);
      end
    end
  end

  // Waveform phase and square amplitude advance once per carrier period while active.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_amp   <= '0;
    end else if (r_state == ST_IDLE || (w_tick && w_next_state == ST_IDLE)) begin
      r_phase <= '0;
      r_amp   <= '0;
    end else if (w_tick) begin
      r_phase <= r_phase + 1'b1;
      if (&r_phase) begin
        r_amp <= r_amp + 1'b1;
      end
    end
  end

  // Shape the target duty for the current phase; triangle falling half is 2*(~phase).
  always_comb begin
    w_target = '0;
    case (r_mode)
      MODE_SQUARE: begin
        if (r_phase >= Q1 && r_phase < Q3) begin
          w_target = {1'b0, r_amp};
        end
      end
      MODE_TRIANGLE: begin
        if (r_phase < HALF) begin
          w_target = {r_phase, 1'b0};
        end else begin
          w_target = {~r_phase, 1'b0};
        end
      end
      MODE_SAW:  w_target = {1'b0, r_phase};
      MODE_FULL: w_target = FULL;
      default:   w_target = '0;
    endcase
  end

  // Sequencer: every decision and duty load happens only at the period tick.
  always_comb begin
    w_next_state = r_state;
    w_duty_next  = r_duty;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_duty_next = '0;
          if (w_clean) begin
            w_next_state = ST_RUN;
            w_duty_next  = w_target;
          end
        end
        ST_RUN: begin
          if (w_clean) begin
            w_duty_next = w_target;
          end else begin
            w_next_state = ST_FADE;
          end
        end
        ST_FADE: begin
          if (w_clean) begin
            w_next_state = ST_RUN;
            w_duty_next  = w_target;
          end else if (r_duty <= STEP) begin
            w_next_state = ST_IDLE;
            w_duty_next  = '0;
          end else begin
            w_duty_next = r_duty - STEP;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_duty_next  = '0;
        end
      endcase
    end
  end

  // State, duty register and the change pulse that marks a new duty word.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_duty   <= '0;
      r_update <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_duty   <= w_duty_next;
      r_update <= (w_duty_next != r_duty);
    end
  end

  assign carrier_cnt  = r_carrier;
  assign duty_cycle   = r_duty;
  assign duty_update  = r_update;
  assign enable_clean = w_clean;
  assign state        = r_state;

endmodule

// File: tb/tb_pwm_envelope_gen.sv
// tb/tb_pwm_envelope_gen.sv - self-checking bench for pwm_envelope_gen
module tb_pwm_envelope_gen;

  localparam int CNT_W      = 6;
  localparam int DEBOUNCE_W = 4;
  localparam int FADE_STEP  = 4;

  logic             sysclk = 1'b0;
  logic             reset;
  logic             enable_sw;
  logic [1:0]       mode_sw;
  logic [CNT_W-1:0] carrier_cnt;
  logic [CNT_W:0]   duty_cycle;
  logic             duty_update;
  logic             enable_clean;
  logic [1:0]       state;

  pwm_envelope_gen #(
    .CNT_W     (CNT_W),
    .DEBOUNCE_W(DEBOUNCE_W),
    .FADE_STEP (FADE_STEP)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable_sw   (enable_sw),
    .mode_sw     (mode_sw),
    .carrier_cnt (carrier_cnt),
    .duty_cycle  (duty_cycle),
    .duty_update (duty_update),
    .enable_clean(enable_clean),
    .state       (state)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int duty;
    int st;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    prev_duty = 0;
  string sect = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    n_cmp++;
    assert (obs === 32'(expv)) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %0d expected %0d", sect, tag, obs, expv);
    end
  endtask

  function automatic int ref_target(input int mode, input int phase, input int amp);
    case (mode)
      0:       return (phase >= 16 && phase < 48) ? amp : 0;
      1:       return (phase < 32) ? 2 * phase : 2 * (63 - phase);
      2:       return phase;
      default: return 64;
    endcase
  endfunction

  task automatic push(input int duty, input int st);
    exp_t e;
    e.duty = duty;
    e.st   = st;
    exp_q.push_back(e);
  endtask

  // Pop one expectation per carrier period boundary (negedge with carrier_cnt == 0).
  task automatic drain();
    exp_t e;
    int   waited;
    while (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      waited = 0;
      do begin
        @(negedge sysclk);
        waited++;
        if (carrier_cnt == 6'd63) check("hold", 32'(duty_cycle), prev_duty);
      end while (carrier_cnt != '0 && waited < 70);
      check("boundary", 32'(carrier_cnt), 0);
      check("duty", 32'(duty_cycle), e.duty);
      check("state", 32'(state), e.st);
      check("update", 32'(duty_update), (e.duty != prev_duty) ? 1 : 0);
      prev_duty = e.duty;
    end
  endtask

  task automatic wait_clean(input int value);
    int waited;
    waited = 0;
    while (enable_clean !== value[0] && waited < 40) begin
      @(negedge sysclk);
      waited++;
    end
    check("clean_wait", 32'(enable_clean), value);
  endtask

  task automatic apply_reset();
    enable_sw = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge sysclk);
    reset     = 1'b0;
    prev_duty = 0;
  endtask

  initial begin
    reset     = 1'b1;
    enable_sw = 1'b0;
    mode_sw   = 2'b00;
    #1;
    check("carrier", 32'(carrier_cnt), 0);
    check("duty", 32'(duty_cycle), 0);
    check("update", 32'(duty_update), 0);
    check("clean", 32'(enable_clean), 0);
    check("state", 32'(state), 0);
    repeat (3) @(negedge sysclk);
    check("carrier_held", 32'(carrier_cnt), 0);
    reset = 1'b0;

    sect = "bounce";
    for (int p = 0; p < 4; p++) begin
      enable_sw = 1'b1;
      repeat (10) begin
        @(negedge sysclk);
        check("clean", 32'(enable_clean), 0);
      end
      enable_sw = 1'b0;
      repeat (10) begin
        @(negedge sysclk);
        check("clean", 32'(enable_clean), 0);
        check("state", 32'(state), 0);
        check("duty", 32'(duty_cycle), 0);
      end
    end

    sect    = "debounce";
    mode_sw = 2'b11;
    @(negedge sysclk);
    enable_sw = 1'b1;
    repeat (17) @(negedge sysclk);
    check("clean_early", 32'(enable_clean), 0);
    @(negedge sysclk);
    check("clean_on", 32'(enable_clean), 1);
    push(64, 1);
    drain();
    @(negedge sysclk);
    check("update_drop", 32'(duty_update), 0);

    sect      = "fade";
    enable_sw = 1'b0;
    push(64, 2);
    for (int d = 60; d >= 4; d -= 4) push(d, 2);
    push(0, 0);
    push(0, 0);
    drain();

    sect      = "refade";
    enable_sw = 1'b1;
    wait_clean(1);
    push(64, 1);
    drain();
    enable_sw = 1'b0;
    push(64, 2);
    for (int d = 60; d >= 32; d -= 4) push(d, 2);
    drain();
    enable_sw = 1'b1;
    push(64, 1);
    drain();

    apply_reset();
    sect    = "saw";
    mode_sw = 2'b10;
    repeat (4) @(negedge sysclk);
    enable_sw = 1'b1;
    wait_clean(1);
    push(0, 1);
    for (int k = 1; k <= 10; k++) push(k - 1, 1);
    drain();
    sect    = "triangle";
    mode_sw = 2'b01;
    for (int k = 11; k <= 64; k++) push(k - 1, 1);
    for (int p = 0; p < 64; p++) push(ref_target(1, p, 0), 1);
    drain();

    apply_reset();
    sect    = "square";
    mode_sw = 2'b00;
    repeat (4) @(negedge sysclk);
    enable_sw = 1'b1;
    wait_clean(1);
    push(0, 1);
    for (int k = 1; k <= 160; k++) push(ref_target(0, (k - 1) % 64, (k - 1) / 64), 1);
    drain();

    sect = "async_reset";
    repeat (20) @(negedge sysclk);
    check("carrier_mid", 32'(carrier_cnt), 20);
    check("duty_mid", 32'(duty_cycle), 2);
    check("state_mid", 32'(state), 1);
    #2;
    reset = 1'b1;
    #1;
    check("duty", 32'(duty_cycle), 0);
    check("carrier", 32'(carrier_cnt), 0);
    check("update", 32'(duty_update), 0);
    check("clean", 32'(enable_clean), 0);
    check("state", 32'(state), 0);
    @(negedge sysclk);
    enable_sw = 1'b0;
    reset     = 1'b0;
    check("carrier_release", 32'(carrier_cnt), 0);
    @(negedge sysclk);
    check("carrier_restart", 32'(carrier_cnt), 1);
    check("duty_after", 32'(duty_cycle), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
